// File: rtl/icb_addr_splt_if.sv
// ICB bundle between one upstream master and SPLT_NUM downstream slaves, as seen by the splitter.
// The slave modport is the splitter's view; the master modport is the surrounding system's view.
interface icb_addr_splt_if #(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int USR_W    = 1,
  parameter int SPLT_NUM = 4
);
  logic                       i_icb_cmd_valid;
  logic                       i_icb_cmd_ready;
  logic                       i_icb_cmd_read;
  logic [AW-1:0]              i_icb_cmd_addr;
  logic [DW-1:0]              i_icb_cmd_wdata;
  logic [DW/8-1:0]            i_icb_cmd_wmask;
  logic [USR_W-1:0]           i_icb_cmd_usr;
  logic                       i_icb_rsp_valid;
  logic                       i_icb_rsp_ready;
  logic                       i_icb_rsp_err;
  logic [DW-1:0]              i_icb_rsp_rdata;
  logic [USR_W-1:0]           i_icb_rsp_usr;

  logic [SPLT_NUM-1:0]        o_bus_icb_cmd_valid;
  logic [SPLT_NUM-1:0]        o_bus_icb_cmd_ready;
  logic [SPLT_NUM-1:0]        o_bus_icb_cmd_read;
  logic [SPLT_NUM*AW-1:0]     o_bus_icb_cmd_addr;
  logic [SPLT_NUM*DW-1:0]     o_bus_icb_cmd_wdata;
  logic [SPLT_NUM*DW/8-1:0]   o_bus_icb_cmd_wmask;
  logic [SPLT_NUM*USR_W-1:0]  o_bus_icb_cmd_usr;
  logic [SPLT_NUM-1:0]        o_bus_icb_rsp_valid;
  logic [SPLT_NUM-1:0]        o_bus_icb_rsp_ready;
  logic [SPLT_NUM-1:0]        o_bus_icb_rsp_err;
  logic [SPLT_NUM*DW-1:0]     o_bus_icb_rsp_rdata;
  logic [SPLT_NUM*USR_W-1:0]  o_bus_icb_rsp_usr;

  modport slave (
    input  i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata,
    input  i_icb_cmd_wmask, i_icb_cmd_usr, i_icb_rsp_ready,
    output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr,
    output o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
    output o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_cmd_usr, o_bus_icb_rsp_ready,
    input  o_bus_icb_cmd_ready, o_bus_icb_rsp_valid, o_bus_icb_rsp_err,
    input  o_bus_icb_rsp_rdata, o_bus_icb_rsp_usr
  );

  modport master (
    output i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata,
    output i_icb_cmd_wmask, i_icb_cmd_usr, i_icb_rsp_ready,
    input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr,
    input  o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
    input  o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_cmd_usr, o_bus_icb_rsp_ready,
    output o_bus_icb_cmd_ready, o_bus_icb_rsp_valid, o_bus_icb_rsp_err,
    output o_bus_icb_rsp_rdata, o_bus_icb_rsp_usr
  );
endinterface

// File: rtl/icb_addr_splt.sv
// ICB 1-to-N address-decoding splitter with in-order responses via an encoded port-id FIFO.
// Command passes through combinationally; response returns >=1 cycle later; full FIFO or per-port limit stalls commands.
module icb_addr_splt #(
  parameter int                     AW            = 32,
  parameter int                     DW            = 64,
  parameter int                     USR_W         = 1,
  parameter int                     SPLT_NUM      = 4,
  parameter int                     OUTS_NUM      = 8,
  parameter int                     PORT_OUTS_MAX = 4,
  parameter logic [SPLT_NUM*AW-1:0] REGION_BASE   = '0,
  parameter logic [SPLT_NUM*AW-1:0] REGION_MASK   = '0,
  parameter logic [63:0]            ERR_RDATA     = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  icb_addr_splt_if.slave            bus,
  output logic [$clog2(OUTS_NUM):0] outs_cnt,
  output logic                      dec_err_evt
);
  localparam int ID_W = $clog2(SPLT_NUM + 1);
  localparam int PW   = $clog2(OUTS_NUM);
  localparam int CW   = $clog2(PORT_OUTS_MAX + 1);
  localparam logic [ID_W-1:0] ID_ERR = ID_W'(SPLT_NUM);

  logic [ID_W-1:0]     r_fifo [OUTS_NUM];
  logic [PW:0]         r_wptr, r_rptr;
  logic [CW-1:0]       r_cnt [SPLT_NUM];
  logic                r_err_pend;
  logic [USR_W-1:0]    r_err_usr;
  logic                r_dec_err;

  logic [ID_W-1:0]     w_sel, w_head;
  logic                w_full, w_empty, w_cmd_ok, w_push, w_pop;
  logic [SPLT_NUM-1:0] w_port_ok, w_cmd_vld, w_bus_rsp_rdy;
  logic                w_rsp_vld, w_rsp_err;
  logic [DW-1:0]       w_rsp_rdata;
  logic [USR_W-1:0]    w_rsp_usr;

  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_head  = r_fifo[r_rptr[PW-1:0]];

  // Descending scan so the lowest matching region index wins.
  always_comb begin
    w_sel = ID_ERR;
    for (int k = SPLT_NUM - 1; k >= 0; k--) begin
      if ((bus.i_icb_cmd_addr & REGION_MASK[k*AW +: AW]) ==
          (REGION_BASE[k*AW +: AW] & REGION_MASK[k*AW +: AW]))
        w_sel = ID_W'(k);
    end
  end

  always_comb begin
    w_cmd_ok  = 1'b0;
    w_cmd_vld = '0;
    w_port_ok = '0;
    for (int k = 0; k < SPLT_NUM; k++) begin
      w_port_ok[k] = r_cnt[k] < CW'(PORT_OUTS_MAX);
      w_cmd_vld[k] = bus.i_icb_cmd_valid && (w_sel == ID_W'(k)) && !w_full && w_port_ok[k];
      if (w_sel == ID_W'(k))
        w_cmd_ok = w_port_ok[k] && bus.o_bus_icb_cmd_ready[k];
    end
    if (w_sel == ID_ERR)
      w_cmd_ok = !r_err_pend;
  end

  assign bus.i_icb_cmd_ready     = !w_full && w_cmd_ok;
  assign bus.o_bus_icb_cmd_valid = w_cmd_vld;
  assign bus.o_bus_icb_cmd_read  = {SPLT_NUM{bus.i_icb_cmd_read}};
  assign bus.o_bus_icb_cmd_addr  = {SPLT_NUM{bus.i_icb_cmd_addr}};
  assign bus.o_bus_icb_cmd_wdata = {SPLT_NUM{bus.i_icb_cmd_wdata}};
  assign bus.o_bus_icb_cmd_wmask = {SPLT_NUM{bus.i_icb_cmd_wmask}};
  assign bus.o_bus_icb_cmd_usr   = {SPLT_NUM{bus.i_icb_cmd_usr}};
  assign w_push = bus.i_icb_cmd_valid && bus.i_icb_cmd_ready;

  always_comb begin
    w_rsp_vld     = 1'b0;
    w_rsp_err     = 1'b0;
    w_rsp_rdata   = '0;
    w_rsp_usr     = '0;
    w_bus_rsp_rdy = '0;
    if (!w_empty) begin
      if (w_head == ID_ERR) begin
        w_rsp_vld   = r_err_pend;
        w_rsp_err   = 1'b1;
        w_rsp_rdata = DW'(ERR_RDATA);
        w_rsp_usr   = r_err_usr;
      end else begin
        for (int k = 0; k < SPLT_NUM; k++) begin
          if (w_head == ID_W'(k)) begin
            w_rsp_vld        = bus.o_bus_icb_rsp_valid[k];
            w_rsp_err        = bus.o_bus_icb_rsp_err[k];
            w_rsp_rdata      = bus.o_bus_icb_rsp_rdata[k*DW +: DW];
            w_rsp_usr        = bus.o_bus_icb_rsp_usr[k*USR_W +: USR_W];
            w_bus_rsp_rdy[k] = bus.i_icb_rsp_ready;
          end
        end
      end
    end
  end

  assign bus.i_icb_rsp_valid     = w_rsp_vld;
  assign bus.i_icb_rsp_err       = w_rsp_err;
  assign bus.i_icb_rsp_rdata     = w_rsp_rdata;
  assign bus.i_icb_rsp_usr       = w_rsp_usr;
  assign bus.o_bus_icb_rsp_ready = w_bus_rsp_rdy;
  assign w_pop = w_rsp_vld && bus.i_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr[PW-1:0]] <= w_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err_pend <= 1'b0;
      r_err_usr  <= '0;
      r_dec_err  <= 1'b0;
      for (int k = 0; k < SPLT_NUM; k++)
        r_cnt[k] <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_dec_err <= w_push && (w_sel == ID_ERR);
      // Accepting an error command needs !r_err_pend and popping one needs r_err_pend, so set/clear never collide.
      if (w_push && (w_sel == ID_ERR)) begin
        r_err_pend <= 1'b1;
        r_err_usr  <= bus.i_icb_cmd_usr;
      end else if (w_pop && (w_head == ID_ERR)) begin
        r_err_pend <= 1'b0;
      end
      for (int k = 0; k < SPLT_NUM; k++) begin
        case ({w_push && (w_sel == ID_W'(k)), w_pop && (w_head == ID_W'(k))})
          2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  assign outs_cnt    = r_wptr - r_rptr;
  assign dec_err_evt = r_dec_err;

  a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (!rst)
    !(w_empty && (|bus.o_bus_icb_rsp_valid)));
endmodule

// File: tb/tb_icb_addr_splt.sv
module tb_icb_addr_splt;
  localparam int N    = 4;
  localparam int OUTS = 8;
  localparam int PMAX = 2;
  localparam logic [63:0] ERRD = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [31:0] BASE_A [N] = '{32'h8000_0000, 32'h1000_0000, 32'h4000_0000, 32'h5000_0000};
  localparam logic [31:0] MASK_A [N] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hE000_0000};

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic        u;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] outs_cnt;
  logic       dec_err_evt;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ord[$];
  rsp_t sq[N][$];
  logic err_usr = 1'b0;
  logic exp_dec = 1'b0;

  always #5 clk = ~clk;

  icb_addr_splt_if #(.AW(32), .DW(64), .USR_W(1), .SPLT_NUM(N)) bus ();

  icb_addr_splt #(
    .AW(32), .DW(64), .USR_W(1), .SPLT_NUM(N), .OUTS_NUM(OUTS), .PORT_OUTS_MAX(PMAX),
    .REGION_BASE({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
    .REGION_MASK({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
    .ERR_RDATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .outs_cnt(outs_cnt), .dec_err_evt(dec_err_evt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic int tgt(input logic [31:0] a);
    for (int k = 0; k < N; k++)
      if ((a & MASK_A[k]) == (BASE_A[k] & MASK_A[k])) return k;
    return N;
  endfunction

  function automatic int cnt_of(input int id);
    int c = 0;
    foreach (ord[i]) if (ord[i] == id) c++;
    return c;
  endfunction

  // One bus cycle: called at posedge+1, drives inputs, checks against the model, ends at next posedge+1.
  task automatic step(input logic cv, input logic [31:0] a, input logic u,
                      input logic [3:0] crdy, input logic [3:0] rvld, input logic rrdy);
    int sel, h;
    logic full, exp_crdy, push, pop, exp_rv;
    logic [3:0] exp_ov, exp_rr, rv_eff;
    rsp_t exp_r, ent;
    sel = tgt(a);
    bus.i_icb_cmd_valid = cv;
    bus.i_icb_cmd_addr  = a;
    bus.i_icb_cmd_read  = 1'($urandom);
    bus.i_icb_cmd_wdata = {$urandom, $urandom};
    bus.i_icb_cmd_wmask = 8'($urandom);
    bus.i_icb_cmd_usr   = u;
    bus.o_bus_icb_cmd_ready = crdy;
    bus.i_icb_rsp_ready = rrdy;
    for (int k = 0; k < N; k++) begin
      rv_eff[k] = rvld[k] && (sq[k].size() != 0);
      if (sq[k].size() != 0) begin
        bus.o_bus_icb_rsp_rdata[k*64 +: 64] = sq[k][0].d;
        bus.o_bus_icb_rsp_err[k] = sq[k][0].e;
        bus.o_bus_icb_rsp_usr[k] = sq[k][0].u;
      end
    end
    bus.o_bus_icb_rsp_valid = rv_eff;
    #2;
    full   = (ord.size() == OUTS);
    exp_ov = '0;
    if (cv && sel < N && !full && cnt_of(sel) < PMAX) exp_ov[sel] = 1'b1;
    if (sel == N) exp_crdy = !full && (cnt_of(N) == 0);
    else          exp_crdy = !full && (cnt_of(sel) < PMAX) && crdy[sel];
    push   = cv && exp_crdy;
    exp_rr = '0;
    exp_rv = 1'b0;
    exp_r  = '{d: 64'd0, e: 1'b0, u: 1'b0};
    if (ord.size() != 0) begin
      h = ord[0];
      if (h == N) begin
        exp_rv = 1'b1;
        exp_r  = '{d: ERRD, e: 1'b1, u: err_usr};
      end else begin
        exp_rv    = rv_eff[h];
        exp_r     = sq[h][0];
        exp_rr[h] = rrdy;
      end
    end
    pop = exp_rv && rrdy;
    chk("cmd_ready", 64'(bus.i_icb_cmd_ready), 64'(exp_crdy));
    chk("bus_cmd_valid", 64'(bus.o_bus_icb_cmd_valid), 64'(exp_ov));
    chk("outs_cnt", 64'(outs_cnt), 64'(ord.size()));
    chk("dec_err_evt", 64'(dec_err_evt), 64'(exp_dec));
    chk("rsp_valid", 64'(bus.i_icb_rsp_valid), 64'(exp_rv));
    chk("bus_rsp_ready", 64'(bus.o_bus_icb_rsp_ready), 64'(exp_rr));
    if (exp_rv) begin
      chk("rsp_err", 64'(bus.i_icb_rsp_err), 64'(exp_r.e));
      chk("rsp_rdata", bus.i_icb_rsp_rdata, exp_r.d);
      chk("rsp_usr", 64'(bus.i_icb_rsp_usr), 64'(exp_r.u));
    end
    if (exp_ov != 0) chk("bcast_addr", 64'(bus.o_bus_icb_cmd_addr[sel*32 +: 32]), 64'(a));
    @(posedge clk);
    #1;
    if (pop) begin
      h = ord.pop_front();
      if (h < N) ent = sq[h].pop_front();
    end
    if (push) begin
      ord.push_back(sel);
      if (sel < N) begin
        ent.d = {$urandom, $urandom};
        ent.e = 1'($urandom);
        ent.u = 1'($urandom);
        sq[sel].push_back(ent);
      end else begin
        err_usr = u;
      end
    end
    exp_dec = push && (sel == N);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && ord.size() != 0; i++) step(1'b0, 32'h0, 1'b0, 4'h0, 4'hF, 1'b1);
    chk("drained", 64'(ord.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] lo = {4'h0, 28'($urandom)};
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000 | lo;
      1: return 32'h1000_0000 | lo;
      2: return 32'h4000_0000 | lo;
      3: return 32'h5000_0000 | lo;
      4: return 32'h2000_0000 | lo;
      default: return 32'h7000_0000 | lo;
    endcase
  endfunction

  initial begin
    bus.i_icb_cmd_valid = 1'b0; bus.i_icb_cmd_read = 1'b0; bus.i_icb_cmd_addr = '0;
    bus.i_icb_cmd_wdata = '0; bus.i_icb_cmd_wmask = '0; bus.i_icb_cmd_usr = '0;
    bus.i_icb_rsp_ready = 1'b0; bus.o_bus_icb_cmd_ready = '0; bus.o_bus_icb_rsp_valid = '0;
    bus.o_bus_icb_rsp_err = '0; bus.o_bus_icb_rsp_rdata = '0; bus.o_bus_icb_rsp_usr = '0;
    #7;
    chk("rst_outs_cnt", 64'(outs_cnt), 64'd0);
    chk("rst_rsp_valid", 64'(bus.i_icb_rsp_valid), 64'd0);
    chk("rst_dec_err", 64'(dec_err_evt), 64'd0);
    chk("rst_bus_cmd_valid", 64'(bus.o_bus_icb_cmd_valid), 64'd0);
    #5 rst = 1'b1;
    @(posedge clk); #1;

    // single read to port 0 and its response
    step(1'b1, 32'h8000_0010, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 4'hF, 4'h1, 1'b1);
    drain();
    // port1 then port0 issued, port0 answers first but must wait
    step(1'b1, 32'h1000_0004, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b1, 32'h8000_0000, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 4'hF, 4'h1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 4'hF, 4'h3, 1'b1);
    step(1'b0, 32'h0, 1'b0, 4'hF, 4'h1, 1'b1);
    drain();
    // unmapped commands: second stalls until the first error response handshakes
    step(1'b1, 32'h2000_0000, 1'b1, 4'hF, 4'h0, 1'b0);
    step(1'b1, 32'h2000_0004, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b1, 32'h2000_0004, 1'b0, 4'hF, 4'h0, 1'b1);
    step(1'b1, 32'h2000_0004, 1'b0, 4'hF, 4'h0, 1'b0);
    drain();
    // per-port limit on port 0
    repeat (3) step(1'b1, 32'h8000_0100, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 4'hF, 4'h1, 1'b1);
    step(1'b1, 32'h8000_0100, 1'b0, 4'hF, 4'h0, 1'b0);
    drain();
    // fill the id FIFO, then pop and push together
    for (int k = 0; k < N; k++) repeat (2) step(1'b1, BASE_A[k] | 32'h40, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b1, 32'h2000_0000, 1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b1, 32'h8000_0000, 1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b0, 4'hF, 4'hF, 1'b1);
    drain();
    // async reset with three outstanding
    repeat (3) step(1'b1, 32'h4000_0000, 1'b0, 4'hF, 4'h0, 1'b0);
    bus.i_icb_cmd_valid = 1'b0;
    bus.o_bus_icb_rsp_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_outs_cnt", 64'(outs_cnt), 64'd0);
    chk("arst_rsp_valid", 64'(bus.i_icb_rsp_valid), 64'd0);
    ord.delete();
    for (int k = 0; k < N; k++) sq[k].delete();
    exp_dec = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h4000_0000, 1'b0, 4'hF, 4'h0, 1'b0);
    drain();

    // randomized traffic
    repeat (1500) step(1'($urandom_range(0, 3) != 0), rnd_addr(), 1'($urandom),
                       4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
